// File: rtl/clk_gen_wb.sv
// clk_gen_wb: Wishbone-programmable divided clock with rising-edge strobe
module clk_gen_wb #(
    parameter logic [3:0] STATUS_ADDR = 4'h0,
    parameter logic [3:0] DIV_ADDR    = 4'h1,
    parameter logic [7:0] DIV_RESET   = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [3:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       clk_out,
    output logic       clk_posedge
);
    logic [7:0] status;
    logic [7:0] div;
    logic [7:0] cnt;
    logic [7:0] rd_data;

    assign rd_data = (adr_i == STATUS_ADDR) ? status :
                     (adr_i == DIV_ADDR)    ? div    : 8'h00;

    // register file, read data capture and single-cycle acknowledge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            status <= 8'h00;
            div    <= DIV_RESET;
            dat_o  <= 8'h00;
            ack_o  <= 1'b0;
        end else begin
            ack_o <= stb_i;
            if (stb_i && we_i && adr_i == STATUS_ADDR) status <= dat_i;
            if (stb_i && we_i && adr_i == DIV_ADDR)    div    <= dat_i;
            if (stb_i && !we_i)                        dat_o  <= rd_data;
        end
    end

    // half-period counter; >= compare lets a smaller DIV take effect without wrapping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt         <= 8'h00;
            clk_out     <= 1'b0;
            clk_posedge <= 1'b0;
        end else if (!status[0]) begin
            cnt         <= 8'h00;
            clk_out     <= 1'b0;
            clk_posedge <= 1'b0;
        end else if (cnt >= div) begin
            cnt         <= 8'h00;
            clk_out     <= ~clk_out;
            clk_posedge <= ~clk_out;
        end else begin
            cnt         <= cnt + 8'h01;
            clk_posedge <= 1'b0;
        end
    end
endmodule

// File: tb/tb_clk_gen_wb.sv
// tb_clk_gen_wb: scoreboard bench for the programmable clock generator
module tb_clk_gen_wb;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [3:0] adr_i = 4'h0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o;
    logic       clk_out;
    logic       clk_posedge;

    typedef struct {
        bit         rd;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    clk_gen_wb dut (
        .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .clk_out(clk_out), .clk_posedge(clk_posedge)
    );

    always #5 clk_i = ~clk_i;

    // cycle counter used to verify ack latency
    always @(posedge clk_i) cyc <= cyc + 1;

    // monitor: every ack consumes one scoreboard entry
    always @(negedge clk_i) begin
        if (rst_i && ack_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL ack_spurious: ack_o=1 with no outstanding access");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.cyc + 1) begin
                    errors++;
                    $display("FAIL ack_latency: got cycle %0d, expected %0d", cyc, e.cyc + 1);
                end
                if (e.rd && dat_o !== e.d) begin
                    errors++;
                    $display("FAIL read_data: dat_o=%h expected %h", dat_o, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input bit we, input logic [3:0] adr, input logic [7:0] d);
        exp_t e;
        @(negedge clk_i);
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        dat_i = d;
        e.rd  = !we;
        e.d   = d;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            stb_i = 1'b0;
        end
    endtask

    // EN must have been written in the access just before this call, from a stopped state
    task automatic check_clk(input int div, input int n);
        int h;
        h = div + 1;
        for (int t = 1; t <= n; t++) begin
            @(negedge clk_i);
            stb_i = 1'b0;
            chk("clk_out", {7'b0, clk_out}, 8'(((t - 1) / h) % 2));
            chk("clk_posedge", {7'b0, clk_posedge}, 8'(((t - 1) % (2 * h)) == h));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_clk_out", {7'b0, clk_out}, 8'h00);
        chk("rst_ack", {7'b0, ack_o}, 8'h00);
        chk("rst_dat", dat_o, 8'h00);
        rst_i = 1'b1;

        access(0, 4'h0, 8'h00);
        access(0, 4'h1, 8'h00);
        idle(2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            chk("idle_clk_out", {7'b0, clk_out}, 8'h00);
        end

        access(1, 4'h2, 8'hFF);
        access(0, 4'h2, 8'h00);
        access(0, 4'h0, 8'h00);
        access(0, 4'h1, 8'h00);
        idle(2);

        for (int i = 0; i < 6; i++) begin
            access(1, 4'h0, 8'(i % 2));
            idle(1);
            access(0, 4'h0, 8'(i % 2));
            idle(2);
        end

        for (int i = 0; i < 256; i++) begin
            access(1, 4'h1, 8'(i));
            access(0, 4'h1, 8'(i));
        end
        idle(2);

        access(1, 4'h0, 8'h00);
        access(1, 4'h1, 8'h03);
        idle(2);
        access(1, 4'h0, 8'h01);
        check_clk(3, 24);

        access(1, 4'h0, 8'h00);
        access(1, 4'h0, 8'hA5);
        access(0, 4'h0, 8'hA5);
        access(1, 4'h0, 8'h00);
        idle(2);
        access(1, 4'h0, 8'hA5);
        check_clk(3, 6);
        access(1, 4'h0, 8'hA4);
        @(negedge clk_i);
        stb_i = 1'b0;
        chk("dis_still_high", {7'b0, clk_out}, 8'h01);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            chk("dis_clk_out", {7'b0, clk_out}, 8'h00);
            chk("dis_posedge", {7'b0, clk_posedge}, 8'h00);
        end
        access(0, 4'h0, 8'hA4);
        idle(2);

        access(1, 4'h0, 8'h00);
        access(1, 4'h1, 8'h05);
        access(0, 4'h1, 8'h05);
        idle(2);
        access(1, 4'h0, 8'h01);
        check_clk(5, 8);
        access(0, 4'h1, 8'h05);
        #2 rst_i = 1'b0;
        q.delete();
        #1;
        chk("arst_clk_out", {7'b0, clk_out}, 8'h00);
        chk("arst_ack", {7'b0, ack_o}, 8'h00);
        chk("arst_dat", dat_o, 8'h00);
        @(negedge clk_i);
        stb_i = 1'b0;
        rst_i = 1'b1;
        access(0, 4'h0, 8'h00);
        access(0, 4'h1, 8'h00);
        idle(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("post_rst_clk_out", {7'b0, clk_out}, 8'h00);
        end

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_ack: %0d accesses never acknowledged, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
